// File: rtl/cv32e40x_rf_write_buffer_pkg.sv
// Shared types and constants for the register file write buffer.
// The register file address and data types match the rest of the core.
package cv32e40x_rf_write_buffer_pkg;

  typedef logic [4:0]  rf_addr_t;
  typedef logic [31:0] rf_data_t;

  localparam int unsigned RF_WBUF_DEPTH = 2;

  typedef struct packed {
    rf_addr_t addr;
    rf_data_t data;
  } rf_wbuf_entry_t;

  // Pointer width that stays legal for a single-entry buffer.
  function automatic int unsigned wbuf_ptr_w(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cv32e40x_rf_wbuf_fwd.sv
// Youngest-match search over the pending entries for one read address.
// Purely combinational; the caller supplies storage, head pointer and occupancy.
module cv32e40x_rf_wbuf_fwd
  import cv32e40x_rf_write_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = RF_WBUF_DEPTH,
  localparam int unsigned PTR_W = wbuf_ptr_w(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  rf_wbuf_entry_t   entries [DEPTH],
  input  logic [PTR_W-1:0] rd_ptr,
  input  logic [CNT_W-1:0] count,
  input  rf_addr_t         raddr,
  output logic             hit,
  output rf_data_t         data
);

  logic [CNT_W-1:0] age [DEPTH];
  logic             match [DEPTH];
  logic [CNT_W-1:0] best_age;

  // Age of a slot is its distance from the head; larger means younger.
  genvar gi;
  generate
    for (gi = 0; gi < int'(DEPTH); gi++) begin : g_slot
      assign age[gi] = (gi >= int'(rd_ptr)) ? CNT_W'(gi - int'(rd_ptr))
                                            : CNT_W'(gi + int'(DEPTH) - int'(rd_ptr));
      assign match[gi] = (age[gi] < count) && (entries[gi].addr == raddr) &&
                         (raddr != '0);
    end
  endgenerate

  always_comb begin
    hit      = 1'b0;
    data     = '0;
    best_age = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (match[i] && (!hit || (age[i] > best_age))) begin
        hit      = 1'b1;
        best_age = age[i];
        data     = entries[i].data;
      end
    end
  end

endmodule

// File: rtl/cv32e40x_rf_write_buffer.sv
// In-order write buffer in front of the register file write port.
// Drains one entry per granted cycle and forwards pending data to snooped reads.
module cv32e40x_rf_write_buffer
  import cv32e40x_rf_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH                  = RF_WBUF_DEPTH,
  parameter int unsigned REGFILE_NUM_READ_PORTS = 2
) (
  input  logic     clk,
  input  logic     rst_n,

  input  logic     wb_valid_i,
  output logic     wb_ready_o,
  input  rf_addr_t wb_waddr_i,
  input  rf_data_t wb_wdata_i,

  output logic     rf_we_o,
  output rf_addr_t rf_waddr_o,
  output rf_data_t rf_wdata_o,
  input  logic     rf_wgnt_i,

  input  rf_addr_t raddr_i    [REGFILE_NUM_READ_PORTS],
  output logic     fwd_hit_o  [REGFILE_NUM_READ_PORTS],
  output rf_data_t fwd_data_o [REGFILE_NUM_READ_PORTS],

  output logic     empty_o
);

  localparam int unsigned PTR_W = wbuf_ptr_w(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  rf_wbuf_entry_t   entries_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg,  count_next;
  logic             push;
  logic             pop;
  rf_wbuf_entry_t   head;

  // Explicit wrap so non-power-of-two depths never index past the last slot.
  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign wb_ready_o = (count_reg != CNT_W'(DEPTH));
  assign rf_we_o    = (count_reg != '0);
  assign empty_o    = (count_reg == '0);

  // Writes to x0 are acknowledged but never stored.
  assign push = wb_valid_i && wb_ready_o && (wb_waddr_i != '0);
  assign pop  = rf_we_o && rf_wgnt_i;

  assign head       = entries_reg[rd_ptr_reg];
  assign rf_waddr_o = rf_we_o ? head.addr : '0;
  assign rf_wdata_o = rf_we_o ? head.data : '0;

  always_comb begin
    rd_ptr_next = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    wr_ptr_next = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    count_next  = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_reg[i] <= '0;
      end
    end else if (push) begin
      entries_reg[wr_ptr_reg] <= '{addr: wb_waddr_i, data: wb_wdata_i};
    end
  end

  // The incoming request is deliberately excluded: only stored entries forward.
  genvar gi;
  generate
    for (gi = 0; gi < int'(REGFILE_NUM_READ_PORTS); gi++) begin : g_fwd
      cv32e40x_rf_wbuf_fwd #(
        .DEPTH (DEPTH)
      ) u_fwd (
        .entries (entries_reg),
        .rd_ptr  (rd_ptr_reg),
        .count   (count_reg),
        .raddr   (raddr_i[gi]),
        .hit     (fwd_hit_o[gi]),
        .data    (fwd_data_o[gi])
      );
    end
  endgenerate

`ifndef SYNTHESIS
  a_depth: assert property (@(posedge clk) DEPTH >= 32'd1);
  a_count: assert property (@(posedge clk) disable iff (!rst_n)
    count_reg <= CNT_W'(DEPTH));
  a_pop_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
    pop |-> (count_reg != '0));
  a_wb_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (wb_valid_i && !wb_ready_o) |=>
      (wb_valid_i && $stable(wb_waddr_i) && $stable(wb_wdata_i)));
`endif

endmodule
